// File: rtl/vctr_frame_tx.sv
// Vector-channel byte link transmitter: serialises three captured channel bytes into a
// marker-delimited, tick-slotted frame. Optional VCTR_TX_REPEAT_EN repeats the last frame forever.
module vctr_frame_tx #(
  parameter int          CLK_DIV      = 625,
  parameter int          SLOTS_PER_CH = 20,
  parameter logic [7:0]  IDLE_BYTE    = 8'hFF
) (
  input  logic       clock,
  input  logic       nrst,
  input  logic [7:0] ch0_data,
  input  logic [7:0] ch1_data,
  input  logic [7:0] ch2_data,
  input  logic       frame_valid,
  output logic       frame_ready,
  output logic [7:0] vctr_data_out,
  output logic       slot_strobe,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] clamp_count
);

  localparam int CNT_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int SLOT_W = (SLOTS_PER_CH > 2) ? $clog2(SLOTS_PER_CH) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOTS_PER_CH - 1);

  typedef enum logic [1:0] {IDLE, PEND, SEND} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  tick_cnt_reg;
  logic [1:0]        ch_idx_reg;
  logic [SLOT_W-1:0] slot_idx_reg;
  logic [7:0]        data_reg;
  logic              frame_ready_reg;
  logic              slot_strobe_reg;
  logic              frame_done_reg;
  logic              busy_reg;
  logic [7:0]        clamp_count_reg;
  logic [7:0]        shadow_reg [3];

  logic              tick;
  logic              accept;
  logic              final_slot;
  logic              restart;
  logic [7:0]        ch_in   [3];
  logic [7:0]        clamped [3];
  logic [2:0]        low;
  logic [1:0]        low_cnt;
  logic [8:0]        clamp_sum;
  logic [1:0]        adv_ch;
  logic [SLOT_W-1:0] adv_slot;
  logic [7:0]        adv_byte;

  assign tick       = (tick_cnt_reg == CNT_LAST);
  assign accept     = frame_valid && frame_ready_reg;
  assign final_slot = (state_reg == SEND) && (ch_idx_reg == 2'd2) && (slot_idx_reg == SLOT_LAST);

  always_ff @(posedge clock) begin
    if (!nrst) begin
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
    end
  end

  assign ch_in[0] = ch0_data;
  assign ch_in[1] = ch1_data;
  assign ch_in[2] = ch2_data;

  // Data below 8'h03 would alias a marker, so it is lifted to 8'h03 at capture.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_clamp
      assign low[gi]     = (ch_in[gi] < 8'h03);
      assign clamped[gi] = low[gi] ? 8'h03 : ch_in[gi];
    end
  endgenerate

  assign low_cnt   = 2'(low[0]) + 2'(low[1]) + 2'(low[2]);
  assign clamp_sum = {1'b0, clamp_count_reg} + 9'(low_cnt);

  always_ff @(posedge clock) begin
    if (!nrst) begin
      shadow_reg[0]   <= '0;
      shadow_reg[1]   <= '0;
      shadow_reg[2]   <= '0;
      clamp_count_reg <= '0;
    end else if (accept) begin
      shadow_reg[0]   <= clamped[0];
      shadow_reg[1]   <= clamped[1];
      shadow_reg[2]   <= clamped[2];
      clamp_count_reg <= clamp_sum[8] ? 8'hFF : clamp_sum[7:0];
    end
  end

  always_comb begin
    adv_ch   = ch_idx_reg;
    adv_slot = slot_idx_reg + SLOT_W'(1);
    if (slot_idx_reg == SLOT_LAST) begin
      adv_ch   = ch_idx_reg + 2'd1;
      adv_slot = '0;
    end
    case (adv_ch)
      2'd0:    adv_byte = shadow_reg[0];
      2'd1:    adv_byte = shadow_reg[1];
      default: adv_byte = shadow_reg[2];
    endcase
    if (adv_slot == '0) begin
      adv_byte = {6'd0, adv_ch};
    end
  end

`ifdef VCTR_TX_REPEAT_EN
  assign restart = 1'b1;
`else
  // Remembers an accept taken earlier in the final slot until the frame boundary.
  logic pend_reg;

  always_ff @(posedge clock) begin
    if (!nrst) begin
      pend_reg <= 1'b0;
    end else if (final_slot && tick) begin
      pend_reg <= 1'b0;
    end else if ((state_reg == SEND) && accept) begin
      pend_reg <= 1'b1;
    end
  end

  assign restart = pend_reg || accept;
`endif

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_reg       <= IDLE;
      ch_idx_reg      <= '0;
      slot_idx_reg    <= '0;
      data_reg        <= IDLE_BYTE;
      frame_ready_reg <= 1'b1;
      slot_strobe_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      slot_strobe_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            frame_ready_reg <= 1'b0;
            busy_reg        <= 1'b1;
            ch_idx_reg      <= '0;
            slot_idx_reg    <= '0;
            if (tick) begin
              state_reg       <= SEND;
              data_reg        <= 8'h00;
              slot_strobe_reg <= 1'b1;
            end else begin
              state_reg <= PEND;
            end
          end
        end
        PEND: begin
          if (tick) begin
            state_reg       <= SEND;
            data_reg        <= 8'h00;
            slot_strobe_reg <= 1'b1;
          end
        end
        SEND: begin
          if (tick) begin
            if (final_slot) begin
              frame_done_reg <= 1'b1;
              if (restart) begin
                ch_idx_reg      <= '0;
                slot_idx_reg    <= '0;
                data_reg        <= 8'h00;
                slot_strobe_reg <= 1'b1;
                frame_ready_reg <= 1'b0;
              end else begin
                state_reg       <= IDLE;
                data_reg        <= IDLE_BYTE;
                frame_ready_reg <= 1'b1;
                busy_reg        <= 1'b0;
              end
            end else begin
              ch_idx_reg      <= adv_ch;
              slot_idx_reg    <= adv_slot;
              data_reg        <= adv_byte;
              slot_strobe_reg <= 1'b1;
              frame_ready_reg <= (adv_ch == 2'd2) && (adv_slot == SLOT_LAST);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign frame_ready   = frame_ready_reg;
  assign vctr_data_out = data_reg;
  assign slot_strobe   = slot_strobe_reg;
  assign frame_done    = frame_done_reg;
  assign busy          = busy_reg;
  assign clamp_count   = clamp_count_reg;

endmodule

// File: tb/tb_vctr_frame_tx.sv
// Directed bench for vctr_frame_tx with CLK_DIV=4, SLOTS_PER_CH=4.
module tb_vctr_frame_tx;

  localparam int CLK_DIV = 4;
  localparam int SPC     = 4;
  localparam int NSLOT   = 3 * SPC;

  logic       clock = 1'b0;
  logic       nrst  = 1'b0;
  logic [7:0] ch0_data = 8'h00;
  logic [7:0] ch1_data = 8'h00;
  logic [7:0] ch2_data = 8'h00;
  logic       frame_valid = 1'b0;
  logic       frame_ready;
  logic [7:0] vctr_data_out;
  logic       slot_strobe;
  logic       frame_done;
  logic       busy;
  logic [7:0] clamp_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  vctr_frame_tx #(.CLK_DIV(CLK_DIV), .SLOTS_PER_CH(SPC), .IDLE_BYTE(8'hFF)) dut (
    .clock         (clock),
    .nrst          (nrst),
    .ch0_data      (ch0_data),
    .ch1_data      (ch1_data),
    .ch2_data      (ch2_data),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .vctr_data_out (vctr_data_out),
    .slot_strobe   (slot_strobe),
    .frame_done    (frame_done),
    .busy          (busy),
    .clamp_count   (clamp_count)
  );

  always #5 clock = ~clock;

  // Edges since reset release; the tick falls on every edge where this is a multiple of CLK_DIV.
  always @(posedge clock) begin
    if (!nrst) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2);
    int c = i / SPC;
    int s = i % SPC;
    if (s == 0) return 8'(c);
    case (c)
      0:       return b0;
      1:       return b1;
      default: return b2;
    endcase
  endfunction

  task automatic align(input int p);
    while (((cyc + 1) % CLK_DIV) != p) @(negedge clock);
  endtask

  task automatic offer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    ch0_data    = b0;
    ch1_data    = b1;
    ch2_data    = b2;
    frame_valid = 1'b1;
    @(negedge clock);
    frame_valid = 1'b0;
    $display("offer %02h/%02h/%02h at edge %0d", b0, b1, b2, cyc);
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!slot_strobe && n < 3 * CLK_DIV);
    check("strobe_seen", slot_strobe, 1);
  endtask

  task automatic run_slots(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int first, input int last);
    int n;
    for (int i = first; i <= last; i++) begin
      wait_strobe(n);
      check($sformatf("slot%0d_data", i), vctr_data_out, exp_byte(i, b0, b1, b2));
      check($sformatf("slot%0d_gap", i), n, CLK_DIV);
      check($sformatf("slot%0d_ready", i), frame_ready, (i == NSLOT - 1));
      check($sformatf("slot%0d_done", i), frame_done, 0);
    end
  endtask

  task automatic finish_idle();
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_done && n < 3 * CLK_DIV);
    check("done_seen", frame_done, 1);
    check("done_gap", n, CLK_DIV);
    check("end_data", vctr_data_out, 8'hFF);
    check("end_busy", busy, 0);
    check("end_ready", frame_ready, 1);
    check("end_strobe", slot_strobe, 0);
    $display("frame end at edge %0d", cyc);
  endtask

  initial begin
    int n;
    int strobes;
    int dones;
    int bad;

    repeat (4) @(negedge clock);
    check("rst_data", vctr_data_out, 8'hFF);
    check("rst_ready", frame_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_clamp", clamp_count, 0);
    nrst = 1'b1;

    strobes = 0; dones = 0; bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (slot_strobe) strobes++;
      if (frame_done) dones++;
      if (vctr_data_out !== 8'hFF || busy !== 1'b0 || frame_ready !== 1'b1) bad++;
    end
    check("idle_strobes", strobes, 0);
    check("idle_dones", dones, 0);
    check("idle_bad_cycles", bad, 0);

    // Basic frame, accepted off-tick.
    align(2);
    offer(8'h10, 8'h20, 8'h30);
    check("pend_busy", busy, 1);
    check("pend_ready", frame_ready, 0);
    check("pend_data", vctr_data_out, 8'hFF);
    wait_strobe(n);
    check("f1_marker0", vctr_data_out, 8'h00);
    run_slots(8'h10, 8'h20, 8'h30, 1, NSLOT - 1);
    finish_idle();

    // Clamping of marker-like data.
    align(3);
    offer(8'h00, 8'h02, 8'h05);
    wait_strobe(n);
    check("f2_marker0", vctr_data_out, 8'h00);
    run_slots(8'h03, 8'h03, 8'h05, 1, NSLOT - 1);
    finish_idle();
    check("clamp_after_f2", clamp_count, 2);

    // Mid-frame offer ignored, final-slot offer restarts with no gap.
    align(1);
    offer(8'h40, 8'h50, 8'h60);
    wait_strobe(n);
    check("f3_marker0", vctr_data_out, 8'h00);
    run_slots(8'h40, 8'h50, 8'h60, 1, 5);
    ch0_data = 8'h77; ch1_data = 8'h00; ch2_data = 8'h99;
    frame_valid = 1'b1;
    run_slots(8'h40, 8'h50, 8'h60, 6, NSLOT - 2);
    frame_valid = 1'b0;
    run_slots(8'h40, 8'h50, 8'h60, NSLOT - 1, NSLOT - 1);
    offer(8'hAA, 8'hBB, 8'hCC);
    wait_strobe(n);
    check("f4_restart_data", vctr_data_out, 8'h00);
    check("f4_restart_done", frame_done, 1);
    check("f4_restart_gap", n, CLK_DIV - 1);
    check("f4_restart_busy", busy, 1);
    run_slots(8'hAA, 8'hBB, 8'hCC, 1, NSLOT - 1);
    finish_idle();
    check("clamp_after_f4", clamp_count, 2);

    // Accept on the tick edge: marker driven at that same edge.
    align(0);
    offer(8'h12, 8'h34, 8'h56);
    check("ontick_strobe", slot_strobe, 1);
    check("ontick_data", vctr_data_out, 8'h00);
    check("ontick_busy", busy, 1);
    check("ontick_ready", frame_ready, 0);
    run_slots(8'h12, 8'h34, 8'h56, 1, NSLOT - 1);
    finish_idle();

    // Accept one cycle after a tick: marker CLK_DIV-1 cycles later.
    align(1);
    offer(8'h9A, 8'hBC, 8'hDE);
    check("late_c0_data", vctr_data_out, 8'hFF);
    check("late_c0_strobe", slot_strobe, 0);
    check("late_c0_busy", busy, 1);
    @(negedge clock);
    check("late_c1_data", vctr_data_out, 8'hFF);
    @(negedge clock);
    check("late_c2_data", vctr_data_out, 8'hFF);
    @(negedge clock);
    check("late_c3_data", vctr_data_out, 8'h00);
    check("late_c3_strobe", slot_strobe, 1);
    run_slots(8'h9A, 8'hBC, 8'hDE, 1, NSLOT - 1);
    finish_idle();

    // Reset in ch1 slot 2.
    align(2);
    offer(8'h01, 8'h44, 8'h55);
    wait_strobe(n);
    check("f7_marker0", vctr_data_out, 8'h00);
    run_slots(8'h03, 8'h44, 8'h55, 1, SPC + 2);
    check("clamp_before_rst", clamp_count, 3);
    nrst = 1'b0;
    @(negedge clock);
    check("mrst_data", vctr_data_out, 8'hFF);
    check("mrst_busy", busy, 0);
    check("mrst_ready", frame_ready, 1);
    check("mrst_strobe", slot_strobe, 0);
    check("mrst_clamp", clamp_count, 0);
    repeat (2) @(negedge clock);
    nrst = 1'b1;
    strobes = 0; bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (slot_strobe) strobes++;
      if (vctr_data_out !== 8'hFF || busy !== 1'b0) bad++;
    end
    check("postrst_strobes", strobes, 0);
    check("postrst_bad_cycles", bad, 0);

    // Tick phase restarts from zero after reset.
    align(0);
    offer(8'h21, 8'h43, 8'h65);
    check("postrst_ontick_data", vctr_data_out, 8'h00);
    check("postrst_ontick_strobe", slot_strobe, 1);
    run_slots(8'h21, 8'h43, 8'h65, 1, NSLOT - 1);
    finish_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
